wci_bias_seq: RTL and testbench

WCI_BIAS_SEQ -- requirements
Module: wci_bias_seq

---
 rtl/wci_bias_seq_pkg.sv | 42 ++++
 rtl/wci_timeout_ctr.sv | 26 ++
 rtl/wci_bias_seq.sv | 116 +++++++++++
 tb/tb_wci_bias_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wci_bias_seq_pkg.sv
// wci_bias_seq_pkg: shared WCI encodings, control op codes and sequencer states.
package wci_bias_seq_pkg;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'd0,
        MCMD_WR   = 3'd1,
        MCMD_RD   = 3'd2
    } mcmd_t;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'd0,
        SRESP_DVA  = 2'd1,
        SRESP_FAIL = 2'd2,
        SRESP_ERR  = 2'd3
    } sresp_t;

    typedef enum logic [2:0] {
        OP_INIT  = 3'd0,
        OP_START = 3'd1,
        OP_STOP  = 3'd2
    } ctl_op_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT_REQ   = 4'd1,
        ST_INIT_WAIT  = 4'd2,
        ST_CFG_REQ    = 4'd3,
        ST_CFG_WAIT   = 4'd4,
        ST_START_REQ  = 4'd5,
        ST_START_WAIT = 4'd6,
        ST_RUN        = 4'd7,
        ST_STOP_REQ   = 4'd8,
        ST_STOP_WAIT  = 4'd9,
        ST_FAULT      = 4'd10
    } state_t;

    // Control ops are selected by MAddr[4:2]; all other address bits stay zero.
    function automatic logic [31:0] ctl_addr(input ctl_op_t op);
        return {27'd0, op, 2'd0};
    endfunction

endpackage

// File: rtl/wci_timeout_ctr.sv
// wci_timeout_ctr: saturating wait-cycle counter; expired once TIMEOUT-1 is reached.
module wci_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            r_cnt <= '0;
        else if (enable && !expired)
            r_cnt <= r_cnt + W'(1);
    end

    assign expired = (r_cnt >= LIMIT);

endmodule

// File: rtl/wci_bias_seq.sv
// wci_bias_seq: WCI master that brings a worker up (INIT, bias CFG write, START)
// and stops it on halt; any error or timeout parks it in FAULT until reset.
module wci_bias_seq
    import wci_bias_seq_pkg::*;
#(
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] BIAS_ADDR = 32'h0
) (
    input  logic        wciM0_Clk,
    input  logic        wciM0_Reset,
    input  logic        go,
    input  logic        halt,
    input  logic [31:0] bias_val,
    output logic [2:0]  wciM0_MCmd,
    output logic        wciM0_MAddrSpace,
    output logic [3:0]  wciM0_MByteEn,
    output logic [31:0] wciM0_MAddr,
    output logic [31:0] wciM0_MData,
    output logic        wciM0_MReset_n,
    input  logic [1:0]  wciM0_SResp,
    input  logic [31:0] wciM0_SData,
    input  logic        wciM0_SThreadBusy,
    output logic        running,
    output logic        fault,
    output logic [31:0] rd_data,
    output logic [3:0]  state
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_bias;
    logic        r_mreset_n;
    logic        w_is_wait;
    logic        w_is_req;
    logic        w_fire;
    logic        w_is_cfg;
    logic        w_dva;
    logic        w_bad;
    logic        w_expired;
    ctl_op_t     w_op;

    assign w_is_wait = (r_state == ST_INIT_WAIT) || (r_state == ST_CFG_WAIT) ||
                       (r_state == ST_START_WAIT) || (r_state == ST_STOP_WAIT);
    assign w_is_req  = (r_state == ST_INIT_REQ) || (r_state == ST_CFG_REQ) ||
                       (r_state == ST_START_REQ) || (r_state == ST_STOP_REQ);
    assign w_dva     = w_is_wait && (sresp_t'(wciM0_SResp) == SRESP_DVA);
    assign w_bad     = w_is_wait && ((sresp_t'(wciM0_SResp) == SRESP_FAIL) ||
                                     (sresp_t'(wciM0_SResp) == SRESP_ERR) || w_expired);

    // Counter is held clear outside waits, so it starts at 0 on each wait entry.
    wci_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (wciM0_Clk),
        .rst     (wciM0_Reset),
        .clear   (!w_is_wait),
        .enable  (w_is_wait),
        .expired (w_expired)
    );

    always_ff @(posedge wciM0_Clk) begin
        if (wciM0_Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       w_state_nxt = go ? ST_INIT_REQ : ST_IDLE;
            ST_INIT_REQ:   w_state_nxt = wciM0_SThreadBusy ? ST_INIT_REQ : ST_INIT_WAIT;
            ST_INIT_WAIT:  w_state_nxt = w_dva ? ST_CFG_REQ : w_bad ? ST_FAULT : ST_INIT_WAIT;
            ST_CFG_REQ:    w_state_nxt = wciM0_SThreadBusy ? ST_CFG_REQ : ST_CFG_WAIT;
            ST_CFG_WAIT:   w_state_nxt = w_dva ? ST_START_REQ : w_bad ? ST_FAULT : ST_CFG_WAIT;
            ST_START_REQ:  w_state_nxt = wciM0_SThreadBusy ? ST_START_REQ : ST_START_WAIT;
            ST_START_WAIT: w_state_nxt = w_dva ? ST_RUN : w_bad ? ST_FAULT : ST_START_WAIT;
            ST_RUN:        w_state_nxt = halt ? ST_STOP_REQ : ST_RUN;
            ST_STOP_REQ:   w_state_nxt = wciM0_SThreadBusy ? ST_STOP_REQ : ST_STOP_WAIT;
            ST_STOP_WAIT:  w_state_nxt = w_dva ? ST_IDLE : w_bad ? ST_FAULT : ST_STOP_WAIT;
            default:       w_state_nxt = ST_FAULT;
        endcase
    end

    always_ff @(posedge wciM0_Clk) begin
        if (wciM0_Reset) begin
            r_bias     <= '0;
            r_mreset_n <= 1'b0;
            rd_data    <= '0;
        end else begin
            r_mreset_n <= 1'b1;
            if (r_state == ST_IDLE && go)
                r_bias <= bias_val;
            if (w_dva)
                rd_data <= wciM0_SData;
        end
    end

    // Gating with reset drops a pending request in the very cycle reset rises.
    assign w_fire   = w_is_req && !wciM0_SThreadBusy && !wciM0_Reset;
    assign w_is_cfg = (r_state == ST_CFG_REQ);
    assign w_op     = (r_state == ST_INIT_REQ)  ? OP_INIT  :
                      (r_state == ST_START_REQ) ? OP_START : OP_STOP;

    always_comb begin
        wciM0_MCmd       = !w_fire ? MCMD_IDLE : w_is_cfg ? MCMD_WR : MCMD_RD;
        wciM0_MAddrSpace = w_fire && w_is_cfg;
        wciM0_MByteEn    = w_fire ? 4'hF : 4'h0;
        wciM0_MAddr      = !w_fire ? 32'd0 : w_is_cfg ? BIAS_ADDR : ctl_addr(w_op);
        wciM0_MData      = (w_fire && w_is_cfg) ? r_bias : 32'd0;
        wciM0_MReset_n   = r_mreset_n && !wciM0_Reset && (r_state != ST_FAULT);
        running          = (r_state == ST_RUN) || (r_state == ST_STOP_REQ) ||
                           (r_state == ST_STOP_WAIT);
        fault            = (r_state == ST_FAULT);
        state            = r_state;
    end

endmodule

// File: tb/tb_wci_bias_seq.sv
// tb_wci_bias_seq: directed bench for the WCI bias bring-up sequencer.
module tb_wci_bias_seq;

    localparam logic [31:0] BADDR = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        halt = 1'b0;
    logic        busy = 1'b0;
    logic [31:0] bias = '0;
    logic [31:0] sdata = '0;
    logic [1:0]  sresp = '0;
    logic [2:0]  mcmd;
    logic        mspace;
    logic [3:0]  mbe;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        mrst_n;
    logic        running;
    logic        fault;
    logic [31:0] rd_data;
    logic [3:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    wci_bias_seq #(.TIMEOUT(16), .BIAS_ADDR(BADDR)) dut (
        .wciM0_Clk         (clk),
        .wciM0_Reset       (rst),
        .go                (go),
        .halt              (halt),
        .bias_val          (bias),
        .wciM0_MCmd        (mcmd),
        .wciM0_MAddrSpace  (mspace),
        .wciM0_MByteEn     (mbe),
        .wciM0_MAddr       (maddr),
        .wciM0_MData       (mdata),
        .wciM0_MReset_n    (mrst_n),
        .wciM0_SResp       (sresp),
        .wciM0_SData       (sdata),
        .wciM0_SThreadBusy (busy),
        .running           (running),
        .fault             (fault),
        .rd_data           (rd_data),
        .state             (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_req(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input logic sp);
        check({tag, "_cmd"}, 32'(mcmd), 32'(cmd));
        check({tag, "_addr"}, maddr, addr);
        check({tag, "_data"}, mdata, data);
        check({tag, "_space"}, 32'(mspace), 32'(sp));
    endtask

    // Drive one response dly cycles after the current request cycle.
    task automatic respond(input int dly, input logic [1:0] r, input logic [31:0] d);
        repeat (dly) @(negedge clk);
        sresp = r;
        sdata = d;
        @(negedge clk);
        sresp = 2'd0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mcmd", 32'(mcmd), 32'd0);
        check("rst_maddr", maddr, 32'd0);
        check("rst_mdata", mdata, 32'd0);
        check("rst_mbe", 32'(mbe), 32'd0);
        check("rst_mrstn", 32'(mrst_n), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_rd", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mrstn_pre", 32'(mrst_n), 32'd0);
        @(negedge clk);
        #1 check("mrstn_post", 32'(mrst_n), 32'd1);

        // Full bring-up, worker answers DVA two cycles after each request
        bias = 32'h0000_0005;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1 check("init_state", 32'(state), 32'd1);
        expect_req("init", 3'd2, 32'd0, 32'd0, 1'b0);
        respond(2, 2'd1, 32'h0000_00A1);
        #1 check("cfg_state", 32'(state), 32'd3);
        expect_req("cfg", 3'd1, BADDR, 32'd5, 1'b1);
        check("cfg_mbe", 32'(mbe), 32'hF);
        check("rd_init", rd_data, 32'h0000_00A1);
        respond(2, 2'd1, 32'h0000_00B2);
        #1 check("start_state", 32'(state), 32'd5);
        expect_req("start", 3'd2, 32'd4, 32'd0, 1'b0);
        respond(2, 2'd1, 32'h0000_00C3);
        #1 check("run_state", 32'(state), 32'd7);
        check("run_running", 32'(running), 32'd1);
        check("run_mcmd", 32'(mcmd), 32'd0);
        check("rd_start", rd_data, 32'h0000_00C3);

        // go and a stray ERR while running are both ignored
        go = 1'b1;
        sresp = 2'd3;
        @(negedge clk);
        go = 1'b0;
        sresp = 2'd0;
        #1 check("run_ign_state", 32'(state), 32'd7);
        check("run_ign_fault", 32'(fault), 32'd0);

        // halt -> STOP (op 2 at MAddr[4:2]) -> IDLE
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        #1 check("stop_state", 32'(state), 32'd8);
        expect_req("stop", 3'd2, 32'd8, 32'd0, 1'b0);
        respond(2, 2'd1, 32'h0000_00D4);
        #1 check("idle_state", 32'(state), 32'd0);
        check("idle_running", 32'(running), 32'd0);

        // Restart with go and halt together: acts as go
        bias = 32'h1234_5678;
        go = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        go = 1'b0;
        halt = 1'b0;
        #1 check("init2_state", 32'(state), 32'd1);
        expect_req("init2", 3'd2, 32'd0, 32'd0, 1'b0);
        respond(2, 2'd1, 32'd0);
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("busy_mcmd", 32'(mcmd), 32'd0);
            check("busy_state", 32'(state), 32'd3);
            @(negedge clk);
        end
        busy = 1'b0;
        #1 expect_req("cfg2", 3'd1, BADDR, 32'h1234_5678, 1'b1);
        @(negedge clk);
        #1 check("cfg2_single", 32'(mcmd), 32'd0);
        check("cfg2_wait", 32'(state), 32'd4);
        respond(0, 2'd1, 32'd0);
        #1 check("start2_state", 32'(state), 32'd5);
        expect_req("start2", 3'd2, 32'd4, 32'd0, 1'b0);

        // No response to START: 16 wait cycles then FAULT
        repeat (16) @(negedge clk);
        #1 check("to_last_wait", 32'(state), 32'd6);
        @(negedge clk);
        #1 check("to_state", 32'(state), 32'd10);
        check("to_fault", 32'(fault), 32'd1);
        check("to_mrstn", 32'(mrst_n), 32'd0);
        check("to_mcmd", 32'(mcmd), 32'd0);
        go = 1'b1;
        sresp = 2'd1;
        @(negedge clk);
        go = 1'b0;
        sresp = 2'd0;
        #1 check("fault_sticky", 32'(state), 32'd10);

        // ERR on INIT -> FAULT, never a CFG write
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst2_fault", 32'(fault), 32'd0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1 check("init3_state", 32'(state), 32'd1);
        respond(1, 2'd3, 32'd0);
        #1 check("err_state", 32'(state), 32'd10);
        check("err_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 6; i++) begin
            #1 check("err_no_cfg", 32'(mcmd), 32'd0);
            @(negedge clk);
        end

        // Reset in CFG_WAIT, then a late DVA
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #1 check("init4_state", 32'(state), 32'd1);
        respond(1, 2'd1, 32'h0000_0055);
        #1 check("cfg4_state", 32'(state), 32'd3);
        @(negedge clk);
        #1 check("cfgw4_state", 32'(state), 32'd4);
        rst = 1'b1;
        #1 check("abort_mcmd", 32'(mcmd), 32'd0);
        @(negedge clk);
        #1 check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_rd", rd_data, 32'd0);
        check("mid_rst_mrstn", 32'(mrst_n), 32'd0);
        check("mid_rst_maddr", maddr, 32'd0);
        check("mid_rst_mdata", mdata, 32'd0);
        sresp = 2'd1;
        sdata = 32'h0000_00EE;
        rst = 1'b0;
        @(negedge clk);
        sresp = 2'd0;
        #1 check("late_dva_state", 32'(state), 32'd0);
        check("late_dva_rd", rd_data, 32'd0);
        check("late_dva_running", 32'(running), 32'd0);
        check("late_dva_mrstn", 32'(mrst_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
